// File: rtl/bist_sequencer_pkg.sv
// Shared definitions for the SRAM BIST controller: default geometry and FSM states.
package bist_sequencer_pkg;

  localparam int unsigned SRAM_ADDR_WIDTH = 8;
  localparam int unsigned SRAM_DATA_WIDTH = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLR0,
    ST_CLR1,
    ST_RUN,
    ST_DRAIN,
    ST_DONE
  } state_t;

  // States in which the BIST engine owns the SRAM port.
  function automatic logic busy_state(input state_t s);
    return (s == ST_CLR0) || (s == ST_CLR1) || (s == ST_RUN) || (s == ST_DRAIN);
  endfunction

endpackage

// File: rtl/bist_comparator.sv
// One-stage read-compare pipeline with first-fail capture and a saturating fail counter.
module bist_comparator
  import bist_sequencer_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = SRAM_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH     = SRAM_DATA_WIDTH,
  parameter int unsigned FAIL_CNT_WIDTH = 11
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      clear,
  input  logic                      flush,
  input  logic                      rd_issue,
  input  logic [DATA_WIDTH-1:0]     exp,
  input  logic [ADDR_WIDTH-1:0]     addr,
  input  logic [DATA_WIDTH-1:0]     rdata,
  output logic [ADDR_WIDTH-1:0]     fail_addr,
  output logic [DATA_WIDTH-1:0]     fail_data,
  output logic [FAIL_CNT_WIDTH-1:0] fail_cnt
);

  logic                  valid;
  logic [DATA_WIDTH-1:0] exp_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic                  first_seen;
  logic                  miss;

  assign miss = valid && (rdata != exp_q);

  // Track the outstanding read, then score its data one cycle later.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid      <= 1'b0;
      exp_q      <= '0;
      addr_q     <= '0;
      first_seen <= 1'b0;
      fail_addr  <= '0;
      fail_data  <= '0;
      fail_cnt   <= '0;
    end else if (flush) begin
      // Abort drops the in-flight compare but keeps accumulated results.
      valid <= 1'b0;
    end else if (clear) begin
      valid      <= 1'b0;
      first_seen <= 1'b0;
      fail_addr  <= '0;
      fail_data  <= '0;
      fail_cnt   <= '0;
    end else begin
      valid  <= rd_issue;
      exp_q  <= exp;
      addr_q <= addr;
      if (miss) begin
        if (fail_cnt != '1) fail_cnt <= fail_cnt + 1'b1;
        if (!first_seen) begin
          first_seen <= 1'b1;
          fail_addr  <= addr_q;
          fail_data  <= rdata;
        end
      end
    end
  end

endmodule

// File: rtl/bist_sequencer.sv
// BIST controller for the shared SRAM: sequences the march counter, muxes the
// SRAM port between functional and BIST use, and reports test results.
module bist_sequencer
  import bist_sequencer_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = SRAM_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH     = SRAM_DATA_WIDTH,
  parameter int unsigned PATTERN_WIDTH  = 1,
  parameter int unsigned FAIL_CNT_WIDTH = 11
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic                      abort,
  output logic                      mc_cen,
  output logic                      mc_rst,
  input  logic [ADDR_WIDTH-1:0]     mc_addr,
  input  logic                      mc_we,
  input  logic [PATTERN_WIDTH-1:0]  mc_pattern,
  input  logic                      mc_done,
  input  logic                      fn_cs,
  input  logic                      fn_we,
  input  logic [ADDR_WIDTH-1:0]     fn_addr,
  input  logic [DATA_WIDTH-1:0]     fn_din,
  output logic [DATA_WIDTH-1:0]     fn_dout,
  output logic                      fn_busy,
  output logic                      sram_cs,
  output logic                      sram_we,
  output logic [ADDR_WIDTH-1:0]     sram_addr,
  output logic [DATA_WIDTH-1:0]     sram_din,
  input  logic [DATA_WIDTH-1:0]     sram_dout,
  output logic                      bist_done,
  output logic                      bist_pass,
  output logic [ADDR_WIDTH-1:0]     fail_addr,
  output logic [DATA_WIDTH-1:0]     fail_data,
  output logic [FAIL_CNT_WIDTH-1:0] fail_cnt
);

  state_t                state, next_state;
  logic                  issue;
  logic [DATA_WIDTH-1:0] pat_word;

  assign pat_word = {DATA_WIDTH{mc_pattern[0]}};
  assign fn_dout  = sram_dout;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= next_state;
  end

  // Next-state, counter control and op-issue decode.
  always_comb begin
    next_state = state;
    mc_rst     = 1'b0;
    mc_cen     = 1'b0;
    issue      = 1'b0;
    case (state)
      ST_IDLE, ST_DONE: if (start) next_state = ST_CLR0;
      ST_CLR0: begin
        mc_rst     = 1'b1;
        next_state = ST_CLR1;
      end
      ST_CLR1: next_state = ST_RUN;
      ST_RUN: begin
        mc_cen = 1'b1;
        if (mc_done) next_state = ST_DRAIN;
        else         issue      = 1'b1;
      end
      ST_DRAIN: next_state = ST_DONE;
      default:  next_state = ST_IDLE;
    endcase
    if (abort) next_state = ST_IDLE;
  end

  // SRAM port mux: march engine while busy, functional port otherwise.
  always_comb begin
    sram_cs   = fn_cs;
    sram_we   = fn_we;
    sram_addr = fn_addr;
    sram_din  = fn_din;
    if (busy_state(state)) begin
      sram_cs   = issue;
      sram_we   = issue && mc_we;
      sram_addr = mc_addr;
      sram_din  = pat_word;
    end
  end

  // Registered status flags, loaded from the upcoming state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fn_busy   <= 1'b0;
      bist_done <= 1'b0;
      bist_pass <= 1'b0;
    end else begin
      fn_busy   <= busy_state(next_state);
      bist_done <= (next_state == ST_DONE);
      bist_pass <= (next_state == ST_DONE) && (fail_cnt == '0);
    end
  end

  bist_comparator #(
    .ADDR_WIDTH    (ADDR_WIDTH),
    .DATA_WIDTH    (DATA_WIDTH),
    .FAIL_CNT_WIDTH(FAIL_CNT_WIDTH)
  ) u_cmp (
    .clk      (clk),
    .rst      (rst),
    .clear    ((state == ST_CLR0) && !abort),
    .flush    (abort),
    .rd_issue (issue && !mc_we && !abort),
    .exp      (pat_word),
    .addr     (mc_addr),
    .rdata    (sram_dout),
    .fail_addr(fail_addr),
    .fail_data(fail_data),
    .fail_cnt (fail_cnt)
  );

endmodule
